// File: rtl/topk_result_buffer.sv
// rtl/topk_result_buffer.sv - dedups top-k search results and replays them over ready/valid
module topk_result_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int K_MAX      = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       start_in,
  input  logic [15:0]                k_in,
  input  logic                       flush_in,
  input  logic [DATA_WIDTH-1:0]      result_in,
  input  logic                       result_valid_in,
  input  logic                       out_ready_in,
  output logic [DATA_WIDTH-1:0]      out_data_out,
  output logic [$clog2(K_MAX)-1:0]   out_index_out,
  output logic                       out_valid_out,
  output logic                       out_last_out,
  output logic [$clog2(K_MAX):0]     count_out,
  output logic                       busy_out,
  output logic                       done_out,
  output logic                       dup_drop_out,
  output logic                       overflow_out
);

  localparam int IW = $clog2(K_MAX);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         keff_q, keff_d;
  logic [IW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  done_q, done_d;
  logic                  dup_q, dup_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_en;
  logic                  match;
  logic                  last;
  logic [CW-1:0]         k_sat;
  logic [DATA_WIDTH-1:0] mem [K_MAX];

  assign k_sat = (k_in >= 16'(K_MAX)) ? CW'(K_MAX) : k_in[CW-1:0];
  assign last  = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));

  // Only entries already stored take part; a write this cycle is seen next cycle.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < K_MAX; i++) begin
      if ((CW'(i) < count_q) && (mem[i] == result_in)) match = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    keff_d   = keff_q;
    rd_ptr_d = rd_ptr_q;
    done_d   = 1'b0;
    dup_d    = 1'b0;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    if (start_in) begin
      count_d  = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      keff_d   = k_sat;
      if (k_sat == '0) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_COLLECT;
      end
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (result_valid_in) begin
            if (match) begin
              dup_d = 1'b1;
            end else begin
              wr_en   = 1'b1;
              count_d = count_q + CW'(1);
            end
          end
          // A result coinciding with flush is stored before the flush takes effect.
          if (count_d == keff_q) begin
            state_d = ST_DRAIN;
          end else if (flush_in) begin
            if (count_d != '0) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (result_valid_in) ovf_d = 1'b1;
          if (out_ready_in) begin
            if (last) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              rd_ptr_d = rd_ptr_q + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      keff_q   <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
      dup_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      keff_q   <= keff_d;
      rd_ptr_q <= rd_ptr_d;
      done_q   <= done_d;
      dup_q    <= dup_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[count_q[IW-1:0]] <= result_in;
  end

  assign out_valid_out = (state_q == ST_DRAIN);
  assign out_data_out  = out_valid_out ? mem[rd_ptr_q] : '0;
  assign out_index_out = out_valid_out ? rd_ptr_q : '0;
  assign out_last_out  = out_valid_out && last;
  assign count_out     = count_q;
  assign busy_out      = (state_q != ST_IDLE);
  assign done_out      = done_q;
  assign dup_drop_out  = dup_q;
  assign overflow_out  = ovf_q;

endmodule

// File: doc/topk_result_buffer.md
# topk_result_buffer

Downstream stage of the best-first search core. Captures the stream of top-k vertex addresses that the search core emits as single-cycle `valid` pulses, drops duplicate addresses, and stores results in arrival order (ascending distance, as produced upstream). Once the requested count arrives, or on an explicit flush, it replays the stored results over a ready/valid handshake to the host/UART readout logic.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of one result (vertex address).
- `K_MAX`, 8: storage depth. Power of two, ≥2.

Ports:
- `clk_in`  input  1  single clock; all logic on its rising edge.
- `rst_n_in`  input  1  reset, asynchronous, active-low.
- `start_in`  input  1  pulse: clear buffer and arm for a new query.
- `k_in`  input  16  requested result count, sampled on `start_in`.
- `flush_in`  input  1  pulse: end collection early with current contents.
- `result_in`  input  DATA_WIDTH  result from the search core.
- `result_valid_in`  input  1  qualifies `result_in`, one cycle per result.
- `out_ready_in`  input  1  consumer ready.
- `out_data_out`  output  DATA_WIDTH  stored result being presented.
- `out_index_out`  output  $clog2(K_MAX)  rank of presented result (0 = nearest).
- `out_valid_out`  output  1  presented result valid.
- `out_last_out`  output  1  presented result is the final one.
- `count_out`  output  $clog2(K_MAX)+1  results currently stored.
- `busy_out`  output  1  high in COLLECT or DRAIN.
- `done_out`  output  1  one-cycle pulse when a query completes.
- `dup_drop_out`  output  1  one-cycle pulse when a duplicate is discarded.
- `overflow_out`  output  1  sticky: a result arrived when it could not be stored.

## Operation
- States: IDLE, COLLECT, DRAIN.
- `k_eff` = min(`k_in`, `K_MAX`), latched on `start_in`.
- IDLE: results are ignored. `start_in` clears count, read pointer and `overflow_out`. If `k_eff` = 0, pulse `done_out` and stay in IDLE. Otherwise go to COLLECT.
- COLLECT: on `result_valid_in`, compare `result_in` combinationally against stored entries 0..count-1.
  - Match: discard and pulse `dup_drop_out` next cycle.
  - No match: write at index count and increment count.
  - When count reaches `k_eff`, go to DRAIN.
- `flush_in` in COLLECT: go to DRAIN if count > 0. If count = 0, go to IDLE and pulse `done_out`.
- DRAIN: present entry[rd_ptr] with `out_valid_out`=1 and `out_last_out` = (rd_ptr == count-1).
  - On `out_valid_out` & `out_ready_in`, advance rd_ptr.
  - On handshake of the last entry, go to IDLE and pulse `done_out`.
  - Data is stable while valid is high and ready is low.
- Any `result_valid_in` in DRAIN sets `overflow_out`; the result is dropped. `result_valid_in` in IDLE is ignored without setting the flag.
- `start_in` in COLLECT or DRAIN aborts the current query: clear everything and re-arm with the new `k_in`. No `done_out` is issued for the aborted query.
- Simultaneous events:
  - `start_in` and `result_valid_in` in the same cycle: the result is dropped.
  - `flush_in` and `result_valid_in` in COLLECT: the result is processed first (dedup/store), then the block enters DRAIN.
  - `flush_in` outside COLLECT is ignored.
- Storage contents are not reset. Only count, pointers, state and flags reset.

## Timing
- Asserting `rst_n_in` low asynchronously forces IDLE. All outputs go to 0, including `out_data_out`, which is gated to 0 when not valid.
- An entry stored on edge N is visible to the dedup compare at edge N+1. Back-to-back identical results therefore drop the second.
- `count_out` updates the cycle after acceptance.
- COLLECT→DRAIN transition occurs on the edge that stores the `k_eff`-th result. `out_valid_out` rises the following cycle.
- One result accepted per cycle. No input backpressure exists; the upstream core cannot stall.
- DRAIN throughput is one result per cycle with `out_ready_in` held high.
- `done_out` rises the cycle after the final handshake (or after `start_in`/`flush_in` for the zero-count cases). It lasts exactly one cycle.
- `busy_out` is registered state decode.

## Test plan
- `k_in`=3, start; results 0x10, 0x20, 0x30 on consecutive cycles; ready high -> DRAIN outputs 0x10/idx0, 0x20/idx1, 0x30/idx2 with last on 0x30; `done_out` pulses once; `overflow_out`=0.
- `k_in`=3; results 0x10, 0x10, 0x20, 0x30 -> `dup_drop_out` pulses once; output 0x10, 0x20, 0x30.
- `k_in`=20 (`K_MAX`=8); 8 distinct results -> `k_eff`=8, DRAIN after the 8th; a 9th result during DRAIN sets `overflow_out`; it stays set until the next start.
- `k_in`=4; 2 results, then `flush_in` in the same cycle as a 3rd -> 3 results drained; separately, `flush_in` with count 0 -> immediate `done_out`, no `out_valid_out`.
- DRAIN with `out_ready_in` toggling 1,0,0,1 -> data and index stable while stalled; no entry skipped or repeated.
- Pull `rst_n_in` low mid-DRAIN asynchronously (between edges) -> outputs 0 immediately; after release, IDLE; a new start with `k_in`=1 completes normally.
